// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
//   Shared encodings for the RV32 decode/control slice: opcodes, ALU codes,
//   result-mux codes, SLT modes, immediate formats and the control bundle that
//   travels from decode into the ID/EX register.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3,
    ALU_XOR = 3'd4, ALU_SLL = 3'd5, ALU_SRA = 3'd6, ALU_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    RES_ALU = 3'd0, RES_MEM = 3'd1, RES_PC4 = 3'd2,
    RES_IMM = 3'd3, RES_PCIMM = 3'd4, RES_MDU = 3'd5
  } result_src_e;

  typedef enum logic [1:0] {
    SLT_NONE = 2'd0, SLT_SIGNED = 2'd1, SLT_UNSIGNED = 2'd2
  } slt_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
  } imm_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        jump_type;
    logic        branch;
    result_src_e result_src;
    logic [2:0]  branch_type;
    alu_op_e     alu_ctrl;
    logic        alu_src;
    slt_ctrl_e   slt_ctrl;
    logic [2:0]  strobe;
    logic [2:0]  mdu_op;
    logic        is_mdu;
  } ctrl_t;

  // Shared by R-type and I-type ALU ops; alt is funct7[5] where it is meaningful.
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010,
      3'b011:  return ALU_SUB;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic slt_ctrl_e slt_sel(input logic [2:0] f3);
    case (f3)
      3'b010:  return SLT_SIGNED;
      3'b011:  return SLT_UNSIGNED;
      default: return SLT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// rv_ctrl_decode
//   Purely combinational RV32I(+M) decoder.
//   instr_i   : instruction word in decode
//   valid_i   : instr_i is a real instruction
//   imm_src_o : immediate format select, independent of validity
//   ctrl_o    : control bundle, all zero when invalid or illegal
//   illegal_o : valid instruction with an unsupported encoding
module rv_ctrl_decode import rv_ctrl_pkg::*; #(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic [2:0]  imm_src_o,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       illegal;
  logic       unused_fields;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  // Register indices are consumed by the datapath, not here.
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    ctrl_o    = '0;
    illegal   = 1'b0;
    imm_src_o = IMM_I;
    case (opcode)
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        if (f7 == 7'b0000001) begin
          if (ENABLE_M) begin
            ctrl_o.is_mdu     = 1'b1;
            ctrl_o.result_src = RES_MDU;
            ctrl_o.mdu_op     = f3;
          end else begin
            illegal = 1'b1;
          end
        end else if (f7 == 7'b0000000 ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          ctrl_o.alu_ctrl = alu_sel(f3, f7[5]);
          ctrl_o.slt_ctrl = slt_sel(f3);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ITYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        // Only shifts carry funct7; elsewhere bit30 is immediate data.
        ctrl_o.alu_ctrl  = alu_sel(f3, (f3 == 3'b101) && f7[5]);
        ctrl_o.slt_ctrl  = slt_sel(f3);
        if (f3 == 3'b001 && f7 != 7'b0000000)
          illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
          illegal = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = RES_MEM;
        ctrl_o.strobe     = f3;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
          illegal = 1'b1;
      end
      OP_STORE: begin
        imm_src_o        = IMM_S;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.strobe    = f3;
        if (f3[2] || f3 == 3'b011)
          illegal = 1'b1;
      end
      OP_BRANCH: begin
        imm_src_o          = IMM_B;
        ctrl_o.branch      = 1'b1;
        ctrl_o.branch_type = f3;
        ctrl_o.alu_ctrl    = ALU_SUB;
        ctrl_o.slt_ctrl    = f3[2] ? (f3[1] ? SLT_UNSIGNED : SLT_SIGNED) : SLT_NONE;
        if (f3 == 3'b010 || f3 == 3'b011)
          illegal = 1'b1;
      end
      OP_JAL: begin
        imm_src_o         = IMM_J;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.jump_type  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = RES_PC4;
        if (f3 != 3'b000)
          illegal = 1'b1;
      end
      OP_LUI: begin
        imm_src_o         = IMM_U;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        imm_src_o         = IMM_U;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_PCIMM;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal || !valid_i)
      ctrl_o = '0;
  end

  assign illegal_o = illegal && valid_i;

endmodule

// File: rtl/rv_decode_ctrl_pipe.sv
// rv_decode_ctrl_pipe
//   RV32 control unit: decode, ID/EX control register (valid/stall/flush) and
//   the IDLE/BUSY sequencer for multi-cycle MUL/DIV.
//   Inputs : CLK, RST (async, active high), InstrD, ValidD, StallE, FlushE, MduDoneE
//   Outputs: ImmSrcD, StallD (combinational); ValidE, IllegalE and the E-stage
//            control bundle; MduStartE / MduKillE one-cycle pulses.
module rv_decode_ctrl_pipe import rv_ctrl_pkg::*; #(
  parameter bit ENABLE_M   = 1'b1,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           InstrD,
  input  logic                  ValidD,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  MduDoneE,
  output logic [2:0]            ImmSrcD,
  output logic                  StallD,
  output logic                  ValidE,
  output logic                  IllegalE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  JumpTypeE,
  output logic                  BranchE,
  output logic [2:0]            ResultSrcE,
  output logic [2:0]            BranchTypeE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  ALUSrcE,
  output logic [1:0]            SLTControlE,
  output logic [2:0]            StrobeE,
  output logic [2:0]            MduOpE,
  output logic                  MduStartE,
  output logic                  MduKillE
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  ctrl_t  dec_ctrl;
  logic   dec_illegal;
  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   valid_q, valid_d;
  logic   illegal_q, illegal_d;
  logic   start_q, start_d;
  logic   kill_q, kill_d;
  logic   load;
  logic   launch;
  logic   unused_is_mdu;

  rv_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr_i   (InstrD),
    .valid_i   (ValidD),
    .imm_src_o (ImmSrcD),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // Done releases decode in the same cycle so the next op can load on that edge.
  assign StallD = (state_q == S_BUSY) && !MduDoneE;
  assign load   = !FlushE && !StallE && !StallD;
  assign launch = load && dec_ctrl.is_mdu;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    kill_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_BUSY;
          start_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (FlushE) begin
          // A result completing on the flush edge is simply dropped; no abort needed.
          state_d = S_IDLE;
          kill_d  = !MduDoneE;
        end else if (MduDoneE) begin
          state_d = launch ? S_BUSY : S_IDLE;
          start_d = launch;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (FlushE) begin
      ctrl_d    = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (load) begin
      ctrl_d    = dec_ctrl;
      valid_d   = ValidD;
      illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      start_q   <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      start_q   <= start_d;
      kill_q    <= kill_d;
    end
  end

  assign unused_is_mdu = ctrl_q.is_mdu;

  assign ValidE      = valid_q;
  assign IllegalE    = illegal_q;
  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign JumpTypeE   = ctrl_q.jump_type;
  assign BranchE     = ctrl_q.branch;
  assign ResultSrcE  = ctrl_q.result_src;
  assign BranchTypeE = ctrl_q.branch_type;
  assign ALUControlE = ALU_CTRL_W'(ctrl_q.alu_ctrl);
  assign ALUSrcE     = ctrl_q.alu_src;
  assign SLTControlE = ctrl_q.slt_ctrl;
  assign StrobeE     = ctrl_q.strobe;
  assign MduOpE      = ctrl_q.mdu_op;
  assign MduStartE   = start_q;
  assign MduKillE    = kill_q;

endmodule

// File: tb/tb_rv_decode_ctrl_pipe.sv
module tb_rv_decode_ctrl_pipe;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] InstrD;
  logic        ValidD, StallE, FlushE, MduDoneE;

  logic [2:0] ImmSrcD, ResultSrcE, BranchTypeE, StrobeE, MduOpE;
  logic       StallD, ValidE, IllegalE, RegWriteE, MemWriteE, JumpE, JumpTypeE, BranchE;
  logic [3:0] ALUControlE;
  logic       ALUSrcE, MduStartE, MduKillE;
  logic [1:0] SLTControlE;

  logic [2:0] m0_ImmSrcD, m0_ResultSrcE, m0_BranchTypeE, m0_StrobeE, m0_MduOpE;
  logic       m0_StallD, m0_ValidE, m0_IllegalE, m0_RegWriteE, m0_MemWriteE, m0_JumpE;
  logic       m0_JumpTypeE, m0_BranchE, m0_ALUSrcE, m0_MduStartE, m0_MduKillE;
  logic [3:0] m0_ALUControlE;
  logic [1:0] m0_SLTControlE;

  rv_decode_ctrl_pipe #(.ENABLE_M(1'b1), .ALU_CTRL_W(4)) dut (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
    .FlushE(FlushE), .MduDoneE(MduDoneE), .ImmSrcD(ImmSrcD), .StallD(StallD),
    .ValidE(ValidE), .IllegalE(IllegalE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .JumpTypeE(JumpTypeE), .BranchE(BranchE), .ResultSrcE(ResultSrcE),
    .BranchTypeE(BranchTypeE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .SLTControlE(SLTControlE), .StrobeE(StrobeE), .MduOpE(MduOpE),
    .MduStartE(MduStartE), .MduKillE(MduKillE)
  );

  rv_decode_ctrl_pipe #(.ENABLE_M(1'b0), .ALU_CTRL_W(4)) dut_m0 (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
    .FlushE(FlushE), .MduDoneE(MduDoneE), .ImmSrcD(m0_ImmSrcD), .StallD(m0_StallD),
    .ValidE(m0_ValidE), .IllegalE(m0_IllegalE), .RegWriteE(m0_RegWriteE),
    .MemWriteE(m0_MemWriteE), .JumpE(m0_JumpE), .JumpTypeE(m0_JumpTypeE),
    .BranchE(m0_BranchE), .ResultSrcE(m0_ResultSrcE), .BranchTypeE(m0_BranchTypeE),
    .ALUControlE(m0_ALUControlE), .ALUSrcE(m0_ALUSrcE), .SLTControlE(m0_SLTControlE),
    .StrobeE(m0_StrobeE), .MduOpE(m0_MduOpE), .MduStartE(m0_MduStartE),
    .MduKillE(m0_MduKillE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       valid, illegal, regw, memw, jump, jtype, branch;
    logic [2:0] rsrc, btype;
    logic [3:0] alu;
    logic       alusrc;
    logic [1:0] slt;
    logic [2:0] strobe, mduop;
    logic       start, kill;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic obs_t sample();
    obs_t o;
    o.valid = ValidE;   o.illegal = IllegalE; o.regw = RegWriteE; o.memw = MemWriteE;
    o.jump = JumpE;     o.jtype = JumpTypeE;  o.branch = BranchE;   o.rsrc = ResultSrcE;
    o.btype = BranchTypeE; o.alu = ALUControlE; o.alusrc = ALUSrcE; o.slt = SLTControlE;
    o.strobe = StrobeE; o.mduop = MduOpE;     o.start = MduStartE; o.kill = MduKillE;
    return o;
  endfunction

  function automatic obs_t mk(input logic [3:0] alu, input logic alusrc,
                              input logic [2:0] rsrc, input logic regw);
    obs_t o;
    o = '0;
    o.valid = 1'b1; o.alu = alu; o.alusrc = alusrc; o.rsrc = rsrc; o.regw = regw;
    return o;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic vd, input logic fl,
                       input logic st, input logic dn);
    InstrD = ins; ValidD = vd; FlushE = fl; StallE = st; MduDoneE = dn;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    RST = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    e = '0;
    got = sample();
    tests++;
    if (got !== e || StallD !== 1'b0) begin
      fails++;
      $display("FAIL reset: got %h stalld %b, expected %h stalld 0", got, StallD, e);
    end
    RST = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] ins [17];
    obs_t        ex  [17];
    logic [2:0]  imm [17];
    logic        ichk[17];
    obs_t        got, e;
    for (int i = 0; i < 17; i++) begin imm[i] = 3'd0; ichk[i] = 1'b0; end
    ins[0]  = 32'h002081B3; ex[0]  = mk(4'd0, 1'b0, 3'd0, 1'b1);
    ins[1]  = 32'h402081B3; ex[1]  = mk(4'd1, 1'b0, 3'd0, 1'b1);
    ins[2]  = 32'h40000093; ex[2]  = mk(4'd0, 1'b1, 3'd0, 1'b1); ichk[2] = 1'b1;
    ins[3]  = 32'h4010D093; ex[3]  = mk(4'd6, 1'b1, 3'd0, 1'b1);
    ins[4]  = 32'h0020A1B3; ex[4]  = mk(4'd1, 1'b0, 3'd0, 1'b1); ex[4].slt = 2'd1;
    ins[5]  = 32'h0020B1B3; ex[5]  = mk(4'd1, 1'b0, 3'd0, 1'b1); ex[5].slt = 2'd2;
    ins[6]  = 32'h0000A083; ex[6]  = mk(4'd0, 1'b1, 3'd1, 1'b1); ex[6].strobe = 3'd2;
    ins[7]  = 32'h0020A023; ex[7]  = mk(4'd0, 1'b1, 3'd0, 1'b0); ex[7].memw = 1'b1;
    ex[7].strobe = 3'd2; imm[7] = 3'd1; ichk[7] = 1'b1;
    ins[8]  = 32'h0020C063; ex[8]  = mk(4'd1, 1'b0, 3'd0, 1'b0); ex[8].branch = 1'b1;
    ex[8].slt = 2'd1; ex[8].btype = 3'd4; imm[8] = 3'd2; ichk[8] = 1'b1;
    ins[9]  = 32'h0000006F; ex[9]  = mk(4'd0, 1'b0, 3'd2, 1'b1); ex[9].jump = 1'b1;
    imm[9] = 3'd3; ichk[9] = 1'b1;
    ins[10] = 32'h00008067; ex[10] = mk(4'd0, 1'b1, 3'd2, 1'b1); ex[10].jump = 1'b1;
    ex[10].jtype = 1'b1; ichk[10] = 1'b1;
    ins[11] = 32'h123450B7; ex[11] = mk(4'd0, 1'b0, 3'd3, 1'b1); imm[11] = 3'd4; ichk[11] = 1'b1;
    ins[12] = 32'h00000097; ex[12] = mk(4'd0, 1'b0, 3'd4, 1'b1); imm[12] = 3'd4; ichk[12] = 1'b1;
    ins[13] = 32'h0020C1B3; ex[13] = mk(4'd4, 1'b0, 3'd0, 1'b1);
    ins[14] = 32'h0020D1B3; ex[14] = mk(4'd7, 1'b0, 3'd0, 1'b1);
    ins[15] = 32'h0020E1B3; ex[15] = mk(4'd3, 1'b0, 3'd0, 1'b1);
    ins[16] = 32'h002091B3; ex[16] = mk(4'd5, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      drive(ins[i], 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(ex[i]);
      step();
      e = exp_q.pop_front();
      got = sample();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL decode[%0d] %h: got %h expected %h", i, ins[i], got, e);
      end
      if (ichk[i]) begin
        tests++;
        if (ImmSrcD !== imm[i]) begin
          fails++;
          $display("FAIL immsrc[%0d]: got %0d expected %0d", i, ImmSrcD, imm[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins[4];
    logic        vd [4];
    obs_t        got, e;
    ins[0] = 32'hFFFFFFFF; vd[0] = 1'b1;
    ins[1] = 32'h802081B3; vd[1] = 1'b1;
    ins[2] = 32'h402091B3; vd[2] = 1'b1;
    ins[3] = I_ADD;        vd[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], vd[i], 1'b0, 1'b0, 1'b0);
      e = '0;
      e.valid = vd[i];
      e.illegal = vd[i] && (i < 3);
      exp_q.push_back(e);
      step();
      e = exp_q.pop_front();
      got = sample();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_mdu();
    obs_t got, e, e_mul;
    e_mul = mk(4'd0, 1'b0, 3'd5, 1'b1);
    drive(I_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
    e = e_mul; e.start = 1'b1;
    exp_q.push_back(e);
    step();
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL mdu_start: got %h expected %h", got, e); end
    tests++;
    if ({m0_ValidE, m0_IllegalE, m0_RegWriteE, m0_MduStartE} !== 4'b1100) begin
      fails++;
      $display("FAIL mdu_disabled: got v/ill/rw/start %b expected 1100",
               {m0_ValidE, m0_IllegalE, m0_RegWriteE, m0_MduStartE});
    end
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    tests++;
    if (StallD !== 1'b1) begin fails++; $display("FAIL stalld_busy: got %b expected 1", StallD); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e_mul);
      step();
      e = exp_q.pop_front(); got = sample();
      tests++;
      if (got !== e) begin fails++; $display("FAIL mdu_hold[%0d]: got %h expected %h", i, got, e); end
    end
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    tests++;
    if (StallD !== 1'b0) begin fails++; $display("FAIL stalld_done: got %b expected 0", StallD); end
    exp_q.push_back(mk(4'd0, 1'b0, 3'd0, 1'b1));
    step();
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL mdu_advance: got %h expected %h", got, e); end
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    drive(I_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
    e = mk(4'd0, 1'b0, 3'd5, 1'b1); e.start = 1'b1;
    exp_q.push_back(e);
    step();
    drive(I_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL b2b_first: got %h expected %h", got, e); end
    e = mk(4'd0, 1'b0, 3'd5, 1'b1);
    exp_q.push_back(e);
    step();
    drive(I_DIV, 1'b1, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL b2b_hold: got %h expected %h", got, e); end
    e = mk(4'd0, 1'b0, 3'd5, 1'b1); e.mduop = 3'd4; e.start = 1'b1;
    exp_q.push_back(e);
    step();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL b2b_second: got %h expected %h", got, e); end
    #1;
    tests++;
    if (StallD !== 1'b1) begin fails++; $display("FAIL b2b_rebusy: got %b expected 1", StallD); end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(obs_t'(0));
    step();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL b2b_drain: got %h expected %h", got, e); end
  endtask

  task automatic test_flush();
    obs_t got, e, e_div;
    e_div = mk(4'd0, 1'b0, 3'd5, 1'b1); e_div.mduop = 3'd4;
    drive(I_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
    e = e_div; e.start = 1'b1;
    exp_q.push_back(e);
    step();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL flush_div_start: got %h expected %h", got, e); end
    exp_q.push_back(e_div);
    step();
    drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL flush_div_hold: got %h expected %h", got, e); end
    e = '0; e.kill = 1'b1;
    exp_q.push_back(e);
    step();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL flush_kill: got %h expected %h", got, e); end
    #1;
    tests++;
    if (StallD !== 1'b0) begin fails++; $display("FAIL flush_stalld: got %b expected 0", StallD); end
    exp_q.push_back(obs_t'(0));
    step();
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL kill_pulse_len: got %h expected %h", got, e); end
    // flush coinciding with done: no abort pulse
    drive(I_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
    e = e_div; e.start = 1'b1;
    exp_q.push_back(e);
    step();
    drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL flushdone_start: got %h expected %h", got, e); end
    exp_q.push_back(obs_t'(0));
    step();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = sample();
    #1;
    tests++;
    if (got !== e || StallD !== 1'b0) begin
      fails++;
      $display("FAIL flush_with_done: got %h stalld %b expected %h stalld 0", got, StallD, e);
    end
  endtask

  task automatic test_stall_e();
    obs_t got, e, e_div;
    e_div = mk(4'd0, 1'b0, 3'd5, 1'b1); e_div.mduop = 3'd4;
    drive(I_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
    e = e_div; e.start = 1'b1;
    exp_q.push_back(e);
    step();
    drive(I_ADD, 1'b1, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL stalle_start: got %h expected %h", got, e); end
    exp_q.push_back(e_div);
    step();
    drive(I_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front(); got = sample();
    #1;
    tests++;
    if (got !== e || StallD !== 1'b0) begin
      fails++;
      $display("FAIL stalle_done: got %h stalld %b expected %h stalld 0", got, StallD, e);
    end
    exp_q.push_back(e_div);
    step();
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL stalle_hold: got %h expected %h", got, e); end
    exp_q.push_back(mk(4'd0, 1'b0, 3'd0, 1'b1));
    step();
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL stalle_release: got %h expected %h", got, e); end
  endtask

  task automatic test_reset_mid();
    obs_t got, e;
    drive(I_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
    e = mk(4'd0, 1'b0, 3'd5, 1'b1); e.mduop = 3'd4; e.start = 1'b1;
    exp_q.push_back(e);
    step();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e) begin fails++; $display("FAIL rstmid_start: got %h expected %h", got, e); end
    #2;
    RST = 1'b1;
    #1;
    got = sample();
    e = '0;
    tests++;
    if (got !== e || StallD !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_busy: got %h stalld %b expected %h stalld 0", got, StallD, e);
    end
    #2;
    RST = 1'b0;
    step();
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk(4'd0, 1'b0, 3'd0, 1'b1));
    step();
    e = exp_q.pop_front(); got = sample();
    tests++;
    if (got !== e || MduKillE !== 1'b0) begin
      fails++;
      $display("FAIL rst_then_add: got %h expected %h", got, e);
    end
  endtask

  initial begin
    RST = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_decode();
    test_illegal();
    test_mdu();
    test_back_to_back();
    test_flush();
    test_stall_e();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
